// File: rtl/bin2bcd_seq_if.sv
// Start/busy/done handshake and result bus of the sequential binary-to-BCD converter.
// The controller drives the master side; the converter implements the slave side.
interface bin2bcd_seq_if #(
  parameter int unsigned BIN_W  = 16,
  parameter int unsigned DIGITS = 5
);
  logic                  start;
  logic [BIN_W-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  overflow;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_out, overflow
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out, overflow
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one binary bit per clock.
// Result and overflow are published with a one-cycle done pulse and held until the next one.
module bin2bcd_seq #(
  parameter int unsigned BIN_W  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic          clk,
  input  logic          rst,
  bin2bcd_seq_if.slave  bus
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   sh_q, sh_d;
  logic [BCD_W-1:0]   work_q, work_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [BCD_W-1:0]   out_q, out_d;
  logic               out_ovf_q, out_ovf_d;
  logic               done_q, done_d;

  logic [BCD_W-1:0]   corr;
  logic [BCD_W-1:0]   shifted;
  logic               carry;

  // Add-3 correction on every digit, then shift in the next binary bit.
  // A 1 leaving the top digit means the value no longer fits in DIGITS digits.
  always_comb begin
    corr = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (work_q[4*i +: 4] >= 4'd5) begin
        corr[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
      end else begin
        corr[4*i +: 4] = work_q[4*i +: 4];
      end
    end
    shifted = {corr[BCD_W-2:0], sh_q[BIN_W-1]};
    carry   = corr[BCD_W-1];
  end

  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    out_d     = out_q;
    out_ovf_d = out_ovf_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sh_d    = bus.bin_in;
          work_d  = '0;
          ovf_d   = 1'b0;
          cnt_d   = CNT_W'(BIN_W);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        work_d = shifted;
        sh_d   = sh_q << 1;
        ovf_d  = ovf_q | carry;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          out_d     = shifted;
          out_ovf_d = ovf_q | carry;
          done_d    = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sh_q      <= '0;
      work_q    <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      out_q     <= '0;
      out_ovf_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      out_q     <= out_d;
      out_ovf_q <= out_ovf_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy     = (state_q == SHIFT);
  assign bus.done     = done_q;
  assign bus.bcd_out  = out_q;
  assign bus.overflow = out_ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: default 16/5 instance plus 8/2 and 8/3 instances.
// Drivers push expected results; one negedge monitor pops and compares on every done.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bin2bcd_seq_if #(.BIN_W(16), .DIGITS(5)) if0 ();
  bin2bcd_seq_if #(.BIN_W(8),  .DIGITS(2)) if1 ();
  bin2bcd_seq_if #(.BIN_W(8),  .DIGITS(3)) if2 ();

  bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  bin2bcd_seq #(.BIN_W(8),  .DIGITS(2)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  bin2bcd_seq #(.BIN_W(8),  .DIGITS(3)) dut2 (.clk(clk), .rst(rst), .bus(if2));

  typedef struct {
    logic [19:0] bcd;
    logic        ov;
    int unsigned cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned q_size(input int id);
    case (id)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic q_push(input int id, input exp_t e);
    case (id)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic q_pop(input int id, output exp_t e);
    case (id)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
  endtask

  function automatic logic busy_of(input int id);
    case (id)
      0:       return if0.busy;
      1:       return if1.busy;
      default: return if2.busy;
    endcase
  endfunction

  // ---------------- monitor ----------------
  logic [19:0] held     [3];
  logic        held_ov  [3];
  int unsigned run      [3];
  logic        done_prev[3];

  task automatic mon(input int id, input int unsigned binw, input logic done, input logic busy,
                     input logic [19:0] bcd, input logic ov);
    exp_t e;
    if (rst) begin
      held[id]      = '0;
      held_ov[id]   = 1'b0;
      run[id]       = 0;
      done_prev[id] = 1'b0;
      return;
    end
    if (done === 1'b1) begin
      check($sformatf("d%0d_done_width", id), 32'(done_prev[id]), 32'd0);
      check($sformatf("d%0d_busy_in_done", id), 32'(busy), 32'd0);
      check($sformatf("d%0d_pending_request", id), 32'(q_size(id) > 0), 32'd1);
      if (q_size(id) > 0) begin
        q_pop(id, e);
        check($sformatf("d%0d_bcd_out", id), 32'(bcd), 32'(e.bcd));
        check($sformatf("d%0d_overflow", id), 32'(ov), 32'(e.ov));
        check($sformatf("d%0d_done_cycle", id), cyc, e.cyc);
        check($sformatf("d%0d_busy_cycles", id), run[id], binw);
        held[id]    = e.bcd;
        held_ov[id] = e.ov;
      end
      run[id] = 0;
    end else begin
      if (busy === 1'b1) run[id]++;
      check($sformatf("d%0d_bcd_held", id), 32'(bcd), 32'(held[id]));
      check($sformatf("d%0d_ov_held", id), 32'(ov), 32'(held_ov[id]));
    end
    done_prev[id] = done;
  endtask

  always @(negedge clk) begin
    mon(0, 16, if0.done, if0.busy, 20'(if0.bcd_out), if0.overflow);
    mon(1, 8,  if1.done, if1.busy, 20'(if1.bcd_out), if1.overflow);
    mon(2, 8,  if2.done, if2.busy, 20'(if2.bcd_out), if2.overflow);
  end

  // ---------------- driver ----------------
  task automatic wait_idle(input int id);
    for (int i = 0; i < 100; i++) begin
      if (busy_of(id) === 1'b0) return;
      @(posedge clk); #1;
    end
    check($sformatf("d%0d_idle_timeout", id), 32'(busy_of(id)), 32'd0);
  endtask

  task automatic set_in(input int id, input logic s, input logic [15:0] val);
    case (id)
      0:       begin if0.start = s; if0.bin_in = val; end
      1:       begin if1.start = s; if1.bin_in = val[7:0]; end
      default: begin if2.start = s; if2.bin_in = val[7:0]; end
    endcase
  endtask

  task automatic issue(input int id, input logic [15:0] val, input logic [19:0] bcd, input logic ov);
    exp_t e;
    wait_idle(id);
    set_in(id, 1'b1, val);
    e.bcd = bcd;
    e.ov  = ov;
    e.cyc = cyc + 1 + ((id == 0) ? 16 : 8);
    q_push(id, e);
    @(posedge clk); #1;
    set_in(id, 1'b0, val);
  endtask

  initial begin
    exp_t e;
    int unsigned h, t, o;
    set_in(0, 1'b0, 16'd0);
    set_in(1, 1'b0, 16'd0);
    set_in(2, 1'b0, 16'd0);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(if0.busy), 32'd0);
    check("rst_done", 32'(if0.done), 32'd0);
    check("rst_bcd", 32'(if0.bcd_out), 32'd0);
    check("rst_ov", 32'(if0.overflow), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    issue(0, 16'd0, 20'h00000, 1'b0);

    // Default-width values
    issue(0, 16'd9,     20'h00009, 1'b0);
    issue(0, 16'd10,    20'h00010, 1'b0);
    issue(0, 16'd12345, 20'h12345, 1'b0);
    issue(0, 16'd65535, 20'h65535, 1'b0);

    // Back-to-back: start held, next operand presented in the done cycle
    wait_idle(0);
    set_in(0, 1'b1, 16'd4321);
    e.bcd = 20'h04321; e.ov = 1'b0; e.cyc = cyc + 17;
    q0.push_back(e);
    repeat (17) begin @(posedge clk); #1; end
    set_in(0, 1'b1, 16'd999);
    e.bcd = 20'h00999; e.ov = 1'b0; e.cyc = cyc + 17;
    q0.push_back(e);
    @(posedge clk); #1;
    set_in(0, 1'b0, 16'd999);

    // start pulses while busy are ignored
    issue(0, 16'd4321, 20'h04321, 1'b0);
    repeat (3) begin
      @(posedge clk); #1; set_in(0, 1'b1, 16'd7);
      @(posedge clk); #1; set_in(0, 1'b0, 16'd7);
    end

    // Reset in the middle of a conversion: no result expected
    wait_idle(0);
    set_in(0, 1'b1, 16'd54321);
    @(posedge clk); #1;
    set_in(0, 1'b0, 16'd54321);
    repeat (7) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", 32'(if0.busy), 32'd0);
    check("midrst_done", 32'(if0.done), 32'd0);
    check("midrst_bcd", 32'(if0.bcd_out), 32'd0);
    @(posedge clk); #1;
    issue(0, 16'd100, 20'h00100, 1'b0);

    // Overflow with two digits
    issue(1, 16'd99,  20'h99, 1'b0);
    issue(1, 16'd100, 20'h00, 1'b1);
    issue(1, 16'd255, 20'h55, 1'b1);
    issue(1, 16'd42,  20'h42, 1'b0);

    // Exhaustive 8-bit with three digits
    for (int v = 0; v < 256; v++) begin
      h = v / 100;
      t = (v / 10) % 10;
      o = v % 10;
      issue(2, 16'(v), 20'((h << 8) | (t << 4) | o), 1'b0);
    end

    for (int i = 0; i < 300; i++) begin
      if (q0.size() + q1.size() + q2.size() == 0) break;
      @(posedge clk); #1;
    end
    check("queue_drained", q0.size() + q1.size() + q2.size(), 32'd0);
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
